fft_butterfly_sequencer: RTL and testbench

- Sequences one shared radix-2 complex floating-point butterfly unit through a full iterative decimation-in-time FFT held in a dual-port sample RAM. The RAM is pre-loaded in bit-reversed order by the loader.
- Per butterfly, generates RAM read/write addresses, the twiddle index and the butterfly start/done handshake.
- Sits between the input loader and the display/readout logic. It replaces the fully unrolled combinational FFT with a time-multiplexed one.
- Signals completion with a single-cycle done pulse.

---
 rtl/fft_butterfly_sequencer.sv | 159 +++++++++++++++
 tb/tb_fft_butterfly_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_butterfly_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fft_butterfly_sequencer
// Brief    : Time-multiplexes one radix-2 complex butterfly unit over an
//            in-place iterative DIT FFT held in a dual-port sample RAM that
//            was pre-loaded in bit-reversed order. Emits the RAM read/write
//            addresses, twiddle index and the butterfly start/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module fft_butterfly_sequencer #(
  parameter int LOG2N = 3,
  parameter int STG_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [STG_W-1:0] stage,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] tw_idx,
  output logic             bf_start,
  input  logic             bf_ready,
  input  logic             bf_done,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b
);

  // Last butterfly index in a stage is N/2-1, i.e. all ones in LOG2N-1 bits.
  localparam logic [LOG2N-2:0] c_K_LAST = '1;
  localparam logic [STG_W-1:0] c_S_LAST = STG_W'(LOG2N - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT_BF = 3'd3,
    S_WRITE   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [STG_W-1:0] stage_q, stage_d;
  logic [LOG2N-2:0] k_q, k_d;
  logic             err_q, err_d;

  logic [LOG2N-2:0] w_mask;
  logic [LOG2N-2:0] w_j;
  logic [LOG2N-2:0] w_grp;
  logic [LOG2N-1:0] w_half;
  logic [LOG2N-1:0] w_addr_a;
  logic [LOG2N-1:0] w_addr_b;
  logic [LOG2N-2:0] w_tw;
  logic             w_active;

  // State, counters and sticky error register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      k_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      k_q     <= k_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: walk k within a stage, then advance the stage.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    k_d     = k_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_READ;
          stage_d = '0;
          k_d     = '0;
          err_d   = 1'b0;
        end
      end
      S_READ:    state_d = S_ISSUE;
      S_ISSUE:   if (bf_ready) state_d = S_WAIT_BF;
      S_WAIT_BF: if (bf_done) state_d = S_WRITE;
      S_WRITE: begin
        if (k_q == c_K_LAST) begin
          if (stage_q == c_S_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_READ;
            k_d     = '0;
            stage_d = stage_q + STG_W'(1);
          end
        end else begin
          state_d = S_READ;
          k_d     = k_q + (LOG2N-1)'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        stage_d = '0;
        k_d     = '0;
      end
      default:   state_d = S_IDLE;
    endcase
    // Abort wins over any sequencing decision; counters return to zero so
    // the idle stage output reads 0.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      stage_d = '0;
      k_d     = '0;
    end
    // A result strobe the sequencer is not waiting for is a protocol error.
    if (bf_done && (state_q != S_WAIT_BF)) begin
      err_d = 1'b1;
    end
  end

  // Butterfly address generation: group = k >> stage, j = k mod 2^stage.
  always_comb begin
    w_mask   = ~({(LOG2N-1){1'b1}} << stage_q);
    w_j      = k_q & w_mask;
    w_grp    = k_q >> stage_q;
    w_half   = LOG2N'(1) << stage_q;
    w_addr_a = ({w_grp, 1'b0} << stage_q) | {1'b0, w_j};
    w_addr_b = w_addr_a | w_half;
    w_tw     = w_j << (c_S_LAST - stage_q);
  end

  // Output decode from registered state; addresses only shown while a
  // butterfly is in flight so idle outputs are all zero.
  always_comb begin
    w_active  = (state_q == S_READ) || (state_q == S_ISSUE) ||
                (state_q == S_WAIT_BF) || (state_q == S_WRITE);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    err       = err_q;
    stage     = stage_q;
    rd_en     = (state_q == S_READ);
    bf_start  = (state_q == S_ISSUE);
    wr_en     = (state_q == S_WRITE);
    rd_addr_a = w_active ? w_addr_a : '0;
    rd_addr_b = w_active ? w_addr_b : '0;
    tw_idx    = w_active ? w_tw : '0;
    wr_addr_a = w_active ? w_addr_a : '0;
    wr_addr_b = w_active ? w_addr_b : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_butterfly_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_butterfly_sequencer
// Brief    : Self-checking bench; butterfly order comes from a nested-loop
//            FFT schedule, with a reactive butterfly-unit responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_butterfly_sequencer;

  localparam int LOG2N = 3;
  localparam int STG_W = 2;
  localparam int NPT   = 8;
  localparam int NB    = 12;

  localparam int LIT_A [NB] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  localparam int LIT_B [NB] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  localparam int LIT_T [NB] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  logic             clk = 1'b0;
  logic             rst, start, abort, bf_ready, bf_done;
  logic             busy, done, err, rd_en, bf_start, wr_en;
  logic [STG_W-1:0] stage;
  logic [LOG2N-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [LOG2N-2:0] tw_idx;

  always #5 clk = ~clk;

  fft_butterfly_sequencer #(.LOG2N(LOG2N), .STG_W(STG_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .err(err), .stage(stage),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .tw_idx(tw_idx), .bf_start(bf_start), .bf_ready(bf_ready),
    .bf_done(bf_done), .wr_en(wr_en), .wr_addr_a(wr_addr_a),
    .wr_addr_b(wr_addr_b)
  );

  int nvec = 0;
  int nmis = 0;
  int exp_a [NB];
  int exp_b [NB];
  int exp_t [NB];
  int exp_s [NB];
  int bfi = 0;
  bit err_exp = 1'b0;
  int cyc_n = 0, st_c = 0, done_c = 0, done_cnt = 0;
  int wr_total = 0, done_total = 0, issue_cnt0 = 0;
  bit prev_start = 1'b0, pending = 1'b0, spur = 1'b0, inj_req = 1'b0, rnd = 1'b0;
  int dcnt = 0, rcnt = 0, first_stall = 0, done_dly = 0;
  int cap_a[$], cap_b[$], cap_t[$];

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_busy"}, int'(busy), 0);
    chk({pfx, "_done"}, int'(done), 0);
    chk({pfx, "_err"}, int'(err), 0);
    chk({pfx, "_stage"}, int'(stage), 0);
    chk({pfx, "_rd_en"}, int'(rd_en), 0);
    chk({pfx, "_rd_a"}, int'(rd_addr_a), 0);
    chk({pfx, "_rd_b"}, int'(rd_addr_b), 0);
    chk({pfx, "_tw"}, int'(tw_idx), 0);
    chk({pfx, "_bf_start"}, int'(bf_start), 0);
    chk({pfx, "_wr_en"}, int'(wr_en), 0);
    chk({pfx, "_wr_a"}, int'(wr_addr_a), 0);
    chk({pfx, "_wr_b"}, int'(wr_addr_b), 0);
  endtask

  // One clock: advance, update the model, compare, then drive the responder.
  task automatic cyc();
    bit acc_start;
    bit acc;
    acc_start = start && !abort && !busy && !rst;
    @(posedge clk);
    #1;
    cyc_n++;
    if (rst) begin
      err_exp = 1'b0;
      bfi     = 0;
      pending = 1'b0;
    end else begin
      if (spur) err_exp = 1'b1;
      if (acc_start) begin
        err_exp    = 1'b0;
        bfi        = 0;
        st_c       = cyc_n - 1;
        done_cnt   = 0;
        issue_cnt0 = 0;
        cap_a.delete(); cap_b.delete(); cap_t.delete();
      end
    end
    spur = 1'b0;
    chk("err", int'(err), int'(err_exp));
    if (rd_en || bf_start || wr_en) begin
      chk("busy_active", int'(busy), 1);
      if (bfi >= NB) begin
        chk("bf_index_range", bfi, NB - 1);
      end else begin
        chk("stage", int'(stage), exp_s[bfi]);
        chk(wr_en ? "wr_addr_a" : "rd_addr_a", int'(wr_en ? wr_addr_a : rd_addr_a), exp_a[bfi]);
        chk(wr_en ? "wr_addr_b" : "rd_addr_b", int'(wr_en ? wr_addr_b : rd_addr_b), exp_b[bfi]);
        chk("tw_idx", int'(tw_idx), exp_t[bfi]);
        if (rd_en) begin
          cap_a.push_back(int'(rd_addr_a));
          cap_b.push_back(int'(rd_addr_b));
          cap_t.push_back(int'(tw_idx));
        end
      end
      if (bf_start && bfi == 0) issue_cnt0++;
      if (wr_en) begin
        bfi++;
        wr_total++;
      end
    end
    if (done) begin
      done_cnt++;
      done_total++;
      done_c = cyc_n;
      chk("done_after_all_writes", bfi, NB);
    end
    // Butterfly unit responder.
    if (!busy) pending = 1'b0;
    acc = prev_start && bf_ready && busy && !bf_start;
    if (acc) begin
      pending = 1'b1;
      dcnt    = rnd ? int'($urandom_range(0, 3)) : done_dly;
    end
    bf_done = 1'b0;
    if (pending) begin
      if (dcnt == 0) begin
        bf_done = 1'b1;
        pending = 1'b0;
      end else begin
        dcnt--;
      end
    end
    if (bf_start && !prev_start) begin
      if (first_stall > 0) rcnt = first_stall;
      else rcnt = rnd ? int'($urandom_range(0, 3)) : 0;
      first_stall = 0;
    end
    if (bf_start) begin
      if (rcnt > 0) begin
        bf_ready = 1'b0;
        rcnt--;
      end else begin
        bf_ready = 1'b1;
      end
    end else begin
      bf_ready = 1'b0;
    end
    if (bf_start && !bf_ready && (inj_req || (rnd && $urandom_range(0, 7) == 0))) begin
      bf_done = 1'b1;
      spur    = 1'b1;
      inj_req = 1'b0;
    end
    prev_start = bf_start;
  endtask

  task automatic run_done(input int maxc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      start = (rnd && busy && $urandom_range(0, 7) == 0);
      cyc();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic kick();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    int n;
    int half;
    bit found;
    int wr0, dn0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; bf_ready = 1'b0; bf_done = 1'b0;
    // FFT schedule: per stage, per group of 2*half, per offset j.
    n = 0;
    for (int s = 0; s < LOG2N; s++) begin
      half = 1 << s;
      for (int base = 0; base < NPT; base += 2 * half) begin
        for (int j = 0; j < half; j++) begin
          exp_a[n] = base + j;
          exp_b[n] = base + j + half;
          exp_t[n] = j * (NPT / (2 * half));
          exp_s[n] = s;
          n++;
        end
      end
    end

    cyc(); cyc();
    chk_zero("reset");
    rst = 1'b0;
    cyc();

    // Basic transform.
    kick();
    chk("first_rd_en", int'(rd_en), 1);
    run_done(200);
    chk("latency_basic", done_c - st_c, 49);
    cyc();
    chk("busy_after_done", int'(busy), 0);
    repeat (3) cyc();
    chk("done_once", done_cnt, 1);
    chk("captured_count", cap_a.size(), NB);
    for (int i = 0; i < NB && i < cap_a.size(); i++) begin
      chk("lit_a", cap_a[i], LIT_A[i]);
      chk("lit_b", cap_b[i], LIT_B[i]);
      chk("lit_tw", cap_t[i], LIT_T[i]);
    end

    // bf_ready stall on butterfly 0.
    first_stall = 5;
    kick();
    run_done(200);
    chk("latency_stall", done_c - st_c, 54);
    chk("issue_cycles_bf0", issue_cnt0, 6);
    cyc();

    // Abort during WAIT_BF of stage 1, k=2.
    done_dly = 3;
    kick();
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (bfi == 6 && busy && !rd_en && !bf_start && !wr_en && !done) begin
        found = 1'b1;
        break;
      end
    end
    chk("abort_window_found", int'(found), 1);
    wr0 = wr_total; dn0 = done_total;
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    repeat (10) cyc();
    chk("abort_no_write", wr_total - wr0, 0);
    chk("abort_no_done", done_total - dn0, 0);
    done_dly = 0;
    kick();
    chk("restart_a", int'(rd_addr_a), 0);
    chk("restart_b", int'(rd_addr_b), 1);
    chk("restart_stage", int'(stage), 0);
    run_done(200);
    chk("latency_restart", done_c - st_c, 49);
    cyc();

    // Spurious bf_done while in ISSUE.
    first_stall = 2;
    inj_req = 1'b1;
    kick();
    run_done(200);
    chk("err_at_done", int'(err), 1);
    chk("latency_spur", done_c - st_c, 51);
    cyc();
    chk("err_held_idle", int'(err), 1);
    kick();
    chk("err_cleared_on_start", int'(err), 0);
    run_done(200);
    cyc();

    // start+abort in IDLE, then start while busy.
    start = 1'b1; abort = 1'b1;
    cyc();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", int'(busy), 0);
    cyc();
    chk("start_abort_idle2", int'(busy), 0);
    kick();
    repeat (10) cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    run_done(200);
    chk("latency_start_busy", done_c - st_c, 49);
    cyc();

    // Reset mid stage 2.
    kick();
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (bfi >= 9 && rd_en) begin
        found = 1'b1;
        break;
      end
    end
    chk("stage2_reached", int'(found), 1);
    rst = 1'b1;
    cyc();
    chk_zero("midrst");
    rst = 1'b0;
    cyc();
    kick();
    run_done(200);
    chk("latency_after_rst", done_c - st_c, 49);
    cyc();

    // Randomized handshakes, spurious strobes and start pulses while busy.
    rnd = 1'b1;
    for (int t = 0; t < 6; t++) begin
      kick();
      run_done(2000);
      cyc();
      chk("rnd_idle_after", int'(busy), 0);
    end
    rnd = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
`default_nettype wire
